// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, transaction
// owner, and the bus-width constants used by the arbiter and its grant picker.
package sram_arbiter_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arbiter_arb_pick.sv
// Combinational grant selection between the fetch and load/store sides.
// Optional macro ARB_ROUND_ROBIN_EN: on a simultaneous request, grant the side
// that did not own the last completed transaction; otherwise data always wins.
module arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic   inst_elig,
  input  logic   data_elig,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t last_owner,
`endif
  output logic   grant,
  output owner_t pick
);

  // Data side by default; fetch only when data is idle (or its turn under RR).
  always_comb begin
    grant = inst_elig | data_elig;
    pick  = data_elig ? OWN_DATA : OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_elig && data_elig) begin
      pick = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter merging a fetch port and a load/store port onto one SRAM-like bus
// master. One outstanding transaction; IDLE -> ADDR (bus_req held until
// addr_ok) -> DATA (wait data_ok) -> IDLE. A flush during a fetch marks it
// cancelled so its data_ok is absorbed silently.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// DATA_W must be 32.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_available,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_available,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              cancel, cancel_nxt;
  logic              wr_nxt;
  logic [3:0]        wstrb_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              grant;
  owner_t            pick;
  logic              done;

  arb_pick u_pick (
    .inst_elig  (inst_req & ~flush),
    .data_elig  (data_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .grant      (grant),
    .pick       (pick)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  // Remember who owned the most recent completed transaction (cancelled ones included).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_owner <= OWN_DATA;
    end else if (done) begin
      last_owner <= owner;
    end
  end
`endif

  // State, owner, cancel flag and latched bus fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= OWN_INST;
      cancel    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cancel    <= cancel_nxt;
      bus_wr    <= wr_nxt;
      bus_wstrb <= wstrb_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
    end
  end

  // Next-state logic: grant in IDLE, hold fields through ADDR, finish on data_ok.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cancel_nxt = cancel;
    wr_nxt     = bus_wr;
    wstrb_nxt  = bus_wstrb;
    addr_nxt   = bus_addr;
    wdata_nxt  = bus_wdata;
    unique case (state)
      ST_IDLE: begin
        cancel_nxt = 1'b0;
        if (grant) begin
          state_nxt = ST_ADDR;
          owner_nxt = pick;
          if (pick == OWN_DATA) begin
            wr_nxt    = data_wr;
            wstrb_nxt = data_wr ? data_sel : 4'b0000;
            addr_nxt  = data_addr;
            wdata_nxt = data_wdata;
          end else begin
            wr_nxt    = 1'b0;
            wstrb_nxt = 4'b0000;
            addr_nxt  = inst_addr;
            wdata_nxt = '0;
          end
        end
      end
      ST_ADDR: begin
        if (flush && owner == OWN_INST) cancel_nxt = 1'b1;
        if (bus_addr_ok) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (flush && owner == OWN_INST) cancel_nxt = 1'b1;
        if (bus_data_ok) begin
          state_nxt  = ST_IDLE;
          cancel_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Completion is combinational from data_ok; a flush arriving with data_ok also kills a fetch.
  always_comb begin
    bus_req        = (state == ST_ADDR);
    done           = (state == ST_DATA) && bus_data_ok;
    inst_available = done && (owner == OWN_INST) && !cancel && !flush;
    data_available = done && (owner == OWN_DATA);
    inst_rdata     = inst_available ? bus_rdata : '0;
    data_rdata     = data_available ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a bus-slave task answers each request,
// expected completions are queued as responses are issued and popped when an
// available pulse appears. Honours ARB_ROUND_ROBIN_EN for grant order.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_available;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_sel = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_available;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  typedef struct {
    logic        side;   // 0 = fetch, 1 = data
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_available(inst_available),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_available(data_available),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Bus slave for one transaction; side picks which request is retired afterwards.
  task automatic serve(input logic [31:0] e_addr, input logic e_wr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input int a_dly, input int d_dly,
                       input logic [31:0] rd, input logic side, input logic kill);
    int   waited = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      waited++;
      if (bus_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("bus_req_timeout", 0, 1);
      return;
    end
    check("grant_latency", waited, 1);
    check("bus_addr", bus_addr, e_addr);
    check("bus_wr", bus_wr, e_wr);
    check("bus_wstrb", bus_wstrb, e_strb);
    if (e_wr) check("bus_wdata", bus_wdata, e_wdata);
    for (int k = 0; k < a_dly; k++) begin
      step;
      check("hold_req", bus_req, 1);
      check("hold_addr", bus_addr, e_addr);
      check("hold_wstrb", bus_wstrb, e_strb);
      check("hold_wr", bus_wr, e_wr);
    end
    bus_addr_ok = 1'b1;
    step;
    bus_addr_ok = 1'b0;
    check("req_drop", bus_req, 0);
    for (int k = 0; k < d_dly; k++) begin
      if (k == 0 && kill) begin
        flush    = 1'b1;
        inst_req = 1'b0;
      end
      step;
      flush = 1'b0;
    end
    if (!kill) sb.push_back('{side: side, data: rd});
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    if (kill) begin
      #3;
      check("cancel_no_pulse", inst_available, 0);
    end
    step;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    if (side) data_req = 1'b0;
    else      inst_req = 1'b0;
  endtask

  // Completion monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_available || data_available) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {inst_available, data_available}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("avail_side", {inst_available, data_available}, mon_e.side ? 2'b01 : 2'b10);
          check("avail_rdata", mon_e.side ? data_rdata : inst_rdata, mon_e.data);
        end
      end
      if (!inst_available) check("inst_rdata_zero", inst_rdata, 0);
      if (!data_available) check("data_rdata_zero", data_rdata, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wstrb", bus_wstrb, 0);
    check("rst_avail", {inst_available, data_available}, 0);
    resetn = 1'b1;

    // Lone fetch, minimum latency
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    serve(32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 0, 0, 32'h3C01_0001, 1'b0, 1'b0);

    // Lone load: wstrb must be zero
    data_addr = 32'h8000_0010; data_wr = 1'b0; data_sel = 4'b1111; data_wdata = 32'h5555_5555;
    data_req  = 1'b1;
    serve(32'h8000_0010, 1'b0, 4'b0000, 32'h0, 0, 1, 32'h1234_5678, 1'b1, 1'b0);

    // Simultaneous fetch and store, last owner is data
    inst_addr = 32'hBFC0_0004;
    data_addr = 32'h8000_1004; data_wr = 1'b1; data_sel = 4'b1111; data_wdata = 32'hDEAD_BEEF;
    inst_req  = 1'b1;
    data_req  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    serve(32'hBFC0_0004, 1'b0, 4'b0000, 32'h0, 0, 0, 32'h2402_0002, 1'b0, 1'b0);
    serve(32'h8000_1004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'hAAAA_5555, 1'b1, 1'b0);
`else
    serve(32'h8000_1004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'hAAAA_5555, 1'b1, 1'b0);
    serve(32'hBFC0_0004, 1'b0, 4'b0000, 32'h0, 0, 0, 32'h2402_0002, 1'b0, 1'b0);
`endif

    // Partial store with addr_ok withheld for 5 cycles
    data_addr = 32'h8000_2000; data_wr = 1'b1; data_sel = 4'b0011; data_wdata = 32'h0000_BEEF;
    data_req  = 1'b1;
    serve(32'h8000_2000, 1'b1, 4'b0011, 32'h0000_BEEF, 5, 1, 32'h0, 1'b1, 1'b0);

    // Fetch flushed in DATA, data_ok 3 cycles later is absorbed
    inst_addr = 32'hBFC0_0008;
    inst_req  = 1'b1;
    serve(32'hBFC0_0008, 1'b0, 4'b0000, 32'h0, 0, 3, 32'hFFFF_0000, 1'b0, 1'b1);
    data_addr = 32'h8000_0020; data_wr = 1'b0; data_sel = 4'b1111;
    data_req  = 1'b1;
    serve(32'h8000_0020, 1'b0, 4'b0000, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);

    // Reset dropped mid-ADDR, then a stray data_ok
    data_addr = 32'h8000_0030; data_wr = 1'b1; data_sel = 4'b1111; data_wdata = 32'h0BAD_0BAD;
    data_req  = 1'b1;
    step;
    check("pre_rst_req", bus_req, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_req", bus_req, 0);
    check("async_rst_addr", bus_addr, 0);
    check("async_rst_wr", bus_wr, 0);
    check("async_rst_wdata", bus_wdata, 0);
    data_req = 1'b0;
    step;
    resetn      = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h7777_7777;
    #3;
    check("stray_ok_data", data_available, 0);
    check("stray_ok_inst", inst_available, 0);
    step;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;

    // Normal fetch after reset
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    serve(32'hBFC0_0000, 1'b0, 4'b0000, 32'h0, 1, 2, 32'h1111_2222, 1'b0, 1'b0);

    step;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width; the module SHALL support only 32.
REQ-003 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port resetn  in  1  reset; asynchronous, active-low.
REQ-005 Port flush  in  1  pipeline flush; cancels the fetch side.
REQ-006 Ports inst_req in 1, inst_addr in ADDR_W: fetch request, held stable until inst_available.
REQ-007 Ports inst_rdata out DATA_W, inst_available out 1: fetch data, and a one-cycle completion pulse.
REQ-008 Ports data_req in 1, data_wr in 1, data_sel in 4, data_addr in ADDR_W, data_wdata in DATA_W: load/store request, held until data_available.
REQ-009 Ports data_rdata out DATA_W, data_available out 1: load data, and a one-cycle completion pulse for loads and stores.
REQ-010 Ports bus_req out 1, bus_wr out 1, bus_wstrb out 4, bus_addr out ADDR_W, bus_wdata out DATA_W: SRAM-like master request.
REQ-011 Ports bus_addr_ok in 1, bus_data_ok in 1, bus_rdata in DATA_W: SRAM-like slave responses.

Function
REQ-012 The block SHALL use an FSM with states IDLE, ADDR and DATA, an owner register (INST/DATA) and a cancel flag.
REQ-013 IDLE: on any eligible request, latch owner and the bus fields into registers, assert bus_req the next cycle, and go to ADDR.
REQ-014 inst_req SHALL be ineligible in any cycle where flush=1.
REQ-015 Arbitration: with data_req and inst_req both eligible, data SHALL win.
REQ-016 bus_wstrb SHALL equal data_sel for data stores, 4'b0000 for loads, and 4'b1111 is never driven for fetches (fetch wstrb=0, wr=0).
REQ-017 ADDR: hold bus_req and all bus fields stable; on bus_addr_ok=1, deassert bus_req next cycle and go to DATA.
REQ-018 DATA: on bus_data_ok=1, pulse the owner's *_available in the same cycle (combinational from data_ok, gated by owner and !cancel), drive *_rdata=bus_rdata, and go to IDLE.
REQ-019 Only one outstanding transaction; a new grant occurs no earlier than the cycle after data_ok.
REQ-020 Minimum latency: request in cycle 0, bus_req in cycle 1; with addr_ok in cycle 1 and data_ok in cycle 2, *_available pulses in cycle 2.
REQ-021 flush=1 while owner=INST in ADDR or DATA SHALL set cancel; bus_req is never withdrawn before addr_ok; the data_ok is absorbed with no inst_available; cancel clears on the return to IDLE.
REQ-022 flush SHALL NOT affect a data-owned transaction, because the data side is gated upstream.
REQ-023 bus_data_ok outside DATA SHALL be ignored.
REQ-024 The non-owner's *_available SHALL remain 0, and *_rdata SHALL be 0 when the matching available is 0.

Reset
REQ-025 resetn=0 SHALL immediately force IDLE, owner=INST, cancel=0, bus_req=0, bus_wr=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, both available=0, even mid-transaction.
REQ-026 After reset, the first grant SHALL occur no earlier than the first rising edge with resetn=1.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on a simultaneous request, grant the requester that did not own the last completed transaction (initially DATA).
REQ-028 Without ARB_ROUND_ROBIN_EN: fixed data priority per REQ-015, and no last-owner register is synthesized.

Structure
REQ-029 The FSM state encoding (IDLE/ADDR/DATA) and owner encoding constants SHALL live in the shared defines header alongside the existing bus-width macros.
REQ-030 One sub-module arb_pick (pure combinational grant selection, holding the round-robin logic under the macro) is natural; all other logic stays in sram_arbiter.

Verification
REQ-031 Lone fetch at 0xBFC00000, addr_ok cycle 1, data_ok cycle 2 with rdata 0x3C010001 -> inst_available pulse in cycle 2 with inst_rdata 0x3C010001.
REQ-032 Simultaneous fetch and store sw to 0x80001004 with sel 4'b1111 -> the bus first shows wr=1, wstrb=4'b1111; data_available precedes inst_available (fixed priority).
REQ-033 The same stimulus with ARB_ROUND_ROBIN_EN and last owner DATA -> fetch granted first.
REQ-034 Fetch in DATA state with flush pulsed, data_ok 3 cycles later -> no inst_available, FSM returns to IDLE, and the next request is granted normally.
REQ-035 addr_ok withheld for 5 cycles -> bus_req and bus fields stay constant over all 5 cycles.
REQ-036 resetn dropped during ADDR -> bus_req=0 asynchronously, and a stray data_ok after reset produces no available pulse.
